// File: rtl/s2mm_ram_writer_ctrl.sv
// Sequencer in front of the S2MM RAM writer: gates the stream on burst boundaries and walks a ping-pong ring of DDR addresses.
// Optional single-fill mode is enabled with `define S2MM_RAM_WRITER_CTRL_ONESHOT_EN (adds cfg_oneshot).
module s2mm_ram_writer_ctrl #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BURST_LENGTH     = 16,
  parameter int BUFFER_LOG2_MAX  = 24
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_base,
  input  logic [4:0]                  cfg_size_log2,
  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic                        cfg_ack,
`ifdef S2MM_RAM_WRITER_CTRL_ONESHOT_EN
  input  logic                        cfg_oneshot,
`endif
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]   address,
  output logic                        running,
  output logic                        half_index,
  output logic                        half_done,
  output logic                        overflow
);

  localparam int BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2(BURST_LENGTH);
  localparam logic [4:0] MIN_LOG2 = 5'($clog2(2 * BURST_LENGTH * BYTES));
  localparam logic [4:0] MAX_LOG2 = 5'(BUFFER_LOG2_MAX);
  localparam logic [AXI_ADDR_WIDTH-1:0] GROUP_BYTES = AXI_ADDR_WIDTH'(BURST_LENGTH * BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_ONE    = AXI_ADDR_WIDTH'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    r_state;
  logic [BEAT_W-1:0]         r_beat_cnt;
  logic [AXI_ADDR_WIDTH-1:0] r_offset;
  logic [4:0]                r_eff_log2;
  logic                      r_half_index;
  logic                      r_half_done;
  logic                      r_overflow;
  logic                      r_running;

  logic                      w_pass;
  logic                      w_hs;
  logic                      w_group_done;
  logic                      w_wrap;
  logic                      w_half_complete;
  logic                      w_oneshot_stop;
  logic [4:0]                w_size_clamped;
  logic [AXI_ADDR_WIDTH-1:0] w_mask;
  logic [AXI_ADDR_WIDTH-1:0] w_half;
  logic [AXI_ADDR_WIDTH-1:0] w_offset_inc;

  // DRAIN keeps passing only until the current group is complete.
  assign w_pass = (r_state == S_RUN) | ((r_state == S_DRAIN) & (r_beat_cnt != '0));
  assign m_axis_tvalid = s_axis_tvalid & w_pass;
  assign s_axis_tready = m_axis_tready & w_pass;
  assign m_axis_tdata  = s_axis_tdata;
  assign w_hs          = m_axis_tvalid & m_axis_tready;

  always_comb begin
    w_size_clamped = cfg_size_log2;
    if (cfg_size_log2 < MIN_LOG2)
      w_size_clamped = MIN_LOG2;
    else if (cfg_size_log2 > MAX_LOG2)
      w_size_clamped = MAX_LOG2;
  end

  assign w_mask          = (ADDR_ONE << r_eff_log2) - ADDR_ONE;
  assign w_half          = ADDR_ONE << (r_eff_log2 - 5'd1);
  assign w_offset_inc    = (r_offset + GROUP_BYTES) & w_mask;
  assign w_group_done    = w_hs & (r_beat_cnt == BEAT_LAST);
  assign w_wrap          = (w_offset_inc == '0);
  assign w_half_complete = w_group_done & (w_wrap | (w_offset_inc == w_half));

`ifdef S2MM_RAM_WRITER_CTRL_ONESHOT_EN
  logic r_oneshot;
  assign w_oneshot_stop = r_oneshot & w_group_done & w_wrap;
`else
  assign w_oneshot_stop = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_offset     <= '0;
      r_eff_log2   <= MIN_LOG2;
      r_half_index <= 1'b0;
      r_half_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_running    <= 1'b0;
`ifdef S2MM_RAM_WRITER_CTRL_ONESHOT_EN
      r_oneshot    <= 1'b0;
`endif
    end else begin
      if (w_hs)
        r_beat_cnt <= r_beat_cnt + BEAT_ONE;
      if (w_group_done)
        r_offset <= w_offset_inc;

      // A completion in the same cycle as an ack re-arms half_done rather than overflowing.
      if (w_half_complete) begin
        r_half_index <= ~r_half_index;
        if (r_half_done & ~cfg_ack & ~w_oneshot_stop)
          r_overflow <= 1'b1;
        else
          r_half_done <= 1'b1;
      end else if (cfg_ack) begin
        r_half_done <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state      <= S_RUN;
            r_running    <= 1'b1;
            r_offset     <= '0;
            r_beat_cnt   <= '0;
            r_half_index <= 1'b0;
            r_half_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_eff_log2   <= w_size_clamped;
`ifdef S2MM_RAM_WRITER_CTRL_ONESHOT_EN
            r_oneshot    <= cfg_oneshot;
`endif
          end
        end
        S_RUN: begin
          if (w_oneshot_stop) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end else if (cfg_stop) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_beat_cnt == '0) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign address    = (cfg_base & ~w_mask) | r_offset;
  assign running    = r_running;
  assign half_index = r_half_index;
  assign half_done  = r_half_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_s2mm_ram_writer_ctrl.sv
// Self-checking bench for s2mm_ram_writer_ctrl: vector table of ring configurations plus hand sequences,
// with a scoreboard of expected {data, address} per accepted sample.
`timescale 1ns/1ps
module tb_s2mm_ram_writer_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_base = 32'h1000_0000;
  logic [4:0]  cfg_size_log2 = 5'd8;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        cfg_ack = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] address;
  logic        running;
  logic        half_index;
  logic        half_done;
  logic        overflow;

  always #5 aclk = ~aclk;

  s2mm_ram_writer_ctrl dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_base      (cfg_base),
    .cfg_size_log2 (cfg_size_log2),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_ack       (cfg_ack),
`ifdef S2MM_RAM_WRITER_CTRL_ONESHOT_EN
    .cfg_oneshot   (1'b0),
`endif
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .address       (address),
    .running       (running),
    .half_index    (half_index),
    .half_done     (half_done),
    .overflow      (overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [31:0] base;
    logic [4:0]  size;
    int          n;
    logic [31:0] exp_addr0;
    logic [31:0] ring;
    bit          exp_hd;
    bit          exp_idx;
    bit          exp_ovf;
  } vec_t;
  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  // Reference model of the ring walk (16 beats x 4 bytes per group)
  int          m_beat;
  logic [31:0] m_off, m_ring, m_base;
  bit          m_idx, m_hd, m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start(input logic [31:0] base, input logic [31:0] ring);
    m_beat = 0; m_off = '0; m_ring = ring; m_base = base;
    m_idx = 1'b0; m_hd = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.addr = m_base | m_off;
    sb_q.push_back(e);
    m_beat++;
    if (m_beat == 16) begin
      m_beat = 0;
      m_off  = (m_off + 32'd64) % m_ring;
      if (m_off == m_ring / 2 || m_off == 0) begin
        if (m_hd) m_ovf = 1'b1;
        else      m_hd  = 1'b1;
        m_idx = ~m_idx;
      end
    end
  endtask

  // Monitor: every handshake pops one expected sample
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      #2;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_hs: got data=0x%0h addr=0x%0h expected no handshake", m_axis_tdata, address);
        end else begin
          e = sb_q.pop_front();
          chk("hs_data", m_axis_tdata, e.data);
          chk("hs_addr", address, e.addr);
          $display("hs %0d data=0x%08h addr=0x%08h", hs_count, m_axis_tdata, address);
        end
      end
    end
  end

  // Offer up to n samples; a sample not taken within 40 cycles ends the stream.
  task automatic stream(input int n, input int stop_at, input bit bp, output int acc);
    int idle;
    bit got;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      got  = 1'b0;
      idle = 0;
      while (!got && idle < 40) begin
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_stop      = (i == stop_at) && m_axis_tready;
        #1;
        if (s_axis_tready) begin
          model_accept(s_axis_tdata);
          got = 1'b1;
        end else begin
          idle++;
        end
      end
      if (!got) break;
      acc++;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    cfg_stop      = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    @(negedge aclk); cfg_start = 1'b1;
    @(negedge aclk); cfg_start = 1'b0;
    #1;
  endtask

  task automatic pulse_ack();
    @(negedge aclk); cfg_ack = 1'b1;
    @(negedge aclk); cfg_ack = 1'b0;
    m_hd = 1'b0;
    #1;
  endtask

  task automatic finish_run(input int exp_drain);
    int acc;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    cfg_stop      = 1'b1;
    stream(32, -1, 1'b0, acc);
    chk("drain_count", acc, exp_drain);
    chk("idle_after_stop", running, 1'b0);
  endtask

  initial begin
    int acc;
    vecs[0] = '{32'h1000_0000, 5'd8,  64, 32'h1000_0000, 32'd256,     1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h1000_0123, 5'd8,  40, 32'h1000_0100, 32'd256,     1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h2000_0000, 5'd3,  16, 32'h2000_0000, 32'd128,     1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h3000_00FF, 5'd7,  32, 32'h3000_0080, 32'd128,     1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h4000_0000, 5'd9,  48, 32'h4000_0000, 32'd512,     1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 5'd31, 20, 32'h1200_0000, 32'h100_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h5000_0010, 5'd0,  17, 32'h5000_0000, 32'd128,     1'b1, 1'b1, 1'b0};

    // Reset state with the stream offered
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_half_done", half_done, 1'b0);
    chk("rst_half_index", half_index, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_address", address, 32'h1000_0000);
    @(negedge aclk);
    aresetn = 1'b1;
    s_axis_tvalid = 1'b0;

    // Vector table: ring configuration, clamp and alignment
    for (int v = 0; v < 7; v++) begin
      cfg_base      = vecs[v].base;
      cfg_size_log2 = vecs[v].size;
      pulse_start();
      model_start(vecs[v].exp_addr0, vecs[v].ring);
      chk($sformatf("v%0d_running", v), running, 1'b1);
      chk($sformatf("v%0d_addr0", v), address, vecs[v].exp_addr0);
      stream(vecs[v].n, -1, 1'b0, acc);
      chk($sformatf("v%0d_accepted", v), acc, vecs[v].n);
      chk($sformatf("v%0d_half_done", v), half_done, vecs[v].exp_hd);
      chk($sformatf("v%0d_half_index", v), half_index, vecs[v].exp_idx);
      chk($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_ovf);
      finish_run((16 - vecs[v].n % 16) % 16);
    end

    // Basic walk with ack between halves
    cfg_base = 32'h1000_0000; cfg_size_log2 = 5'd8;
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    stream(31, -1, 1'b0, acc);
    chk("walk_hd_before_half", half_done, 1'b0);
    stream(1, -1, 1'b0, acc);
    chk("walk_hd_half", half_done, 1'b1);
    chk("walk_idx_half", half_index, 1'b1);
    chk("walk_addr_half", address, 32'h1000_0080);
    pulse_ack();
    chk("walk_ack_clears", half_done, 1'b0);
    stream(32, -1, 1'b0, acc);
    chk("walk_hd_wrap", half_done, 1'b1);
    chk("walk_idx_wrap", half_index, 1'b0);
    chk("walk_ovf_wrap", overflow, 1'b0);
    chk("walk_addr_wrap", address, 32'h1000_0000);
    finish_run(0);

    // Overflow, ack clears only half_done, start ignored in RUN, restart clears overflow
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    stream(64, -1, 1'b0, acc);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_hd_kept", half_done, 1'b1);
    pulse_ack();
    chk("ovf_ack_hd", half_done, 1'b0);
    chk("ovf_ack_keeps_ovf", overflow, 1'b1);
    pulse_start();
    chk("ovf_start_in_run", overflow, 1'b1);
    finish_run(0);
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    chk("ovf_restart_clears", overflow, 1'b0);
    finish_run(0);

    // Stop mid-group finishes the burst
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    stream(40, 5, 1'b0, acc);
    chk("stop_mid_count", acc, 16);
    chk("stop_mid_tready", s_axis_tready, 1'b0);
    chk("stop_mid_running", running, 1'b0);
    chk("stop_mid_addr", address, 32'h1000_0040);

    // Stop on a group boundary admits nothing further
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    stream(16, -1, 1'b0, acc);
    @(negedge aclk); cfg_stop = 1'b1;
    @(negedge aclk); cfg_stop = 1'b0;
    stream(8, -1, 1'b0, acc);
    chk("stop_b0_count", acc, 0);
    chk("stop_b0_running", running, 1'b0);

    // Backpressure
    pulse_start();
    model_start(32'h1000_0000, 32'd256);
    stream(64, -1, 1'b1, acc);
    chk("bp_count", acc, 64);
    chk("bp_half_done", half_done, 1'b1);
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_addr", address, 32'h1000_0000);
    finish_run(0);

    // Reset mid-RUN at beat 9
    cfg_base = 32'h1000_0123;
    pulse_start();
    model_start(32'h1000_0100, 32'd256);
    stream(9, -1, 1'b0, acc);
    @(negedge aclk); aresetn = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge aclk); s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    #1;
    chk("mrst_s_tready", s_axis_tready, 1'b0);
    chk("mrst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("mrst_running", running, 1'b0);
    chk("mrst_half_index", half_index, 1'b0);
    chk("mrst_address", address, 32'h1000_0100);
    @(negedge aclk); aresetn = 1'b1; s_axis_tvalid = 1'b0;
    pulse_start();
    model_start(32'h1000_0100, 32'd256);
    chk("mrst_restart_addr", address, 32'h1000_0100);
    stream(16, -1, 1'b0, acc);
    chk("mrst_count", acc, 16);
    chk("mrst_addr_next", address, 32'h1000_0140);
    finish_run(0);

    repeat (2) @(negedge aclk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s2mm_ram_writer_ctrl.md
Name: s2mm_ram_writer_ctrl

Overview:
- Sequencer in front of the S2MM RAM writer.
- Gates the incoming AXI-Stream into the writer and generates the per-sample DDR `address` the writer packs alongside each sample.
- Addresses walk a power-of-two ring buffer (ping-pong halves) one burst per BURST_LENGTH samples. Completion of each half is flagged to the PS.
- Start/stop are honoured only on burst boundaries, so the writer FIFO only ever receives whole bursts.

Parameters:
- AXI_ADDR_WIDTH, 32, width of DDR byte addresses.
- AXI_DATA_WIDTH, 32, writer beat width; BYTES = AXI_DATA_WIDTH/8.
- AXIS_TDATA_WIDTH, 32, stream data width.
- BURST_LENGTH, 16, beats per writer burst; power of two.
- BUFFER_LOG2_MAX, 24, largest allowed ring size (log2 bytes).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- cfg_base  in  AXI_ADDR_WIDTH  ring base address; must be size-aligned, low bits below size ignored
- cfg_size_log2  in  5  ring size, log2 bytes; latched on start
- cfg_start  in  1  single-cycle start pulse
- cfg_stop  in  1  single-cycle stop pulse
- cfg_ack  in  1  PS acknowledges the pending half_done
- s_axis_tdata  in  AXIS_TDATA_WIDTH  upstream sample
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  to writer S_AXIS_tdata; passthrough
- m_axis_tvalid  out  1  to writer
- m_axis_tready  in  1  from writer
- address  out  AXI_ADDR_WIDTH  to writer address input
- running  out  1  high in RUN or DRAIN
- half_index  out  1  half currently being filled
- half_done  out  1  sticky until cfg_ack; set when a half completes
- overflow  out  1  sticky; a half completed while half_done was still set

Behaviour:
- Reset values: state IDLE, beat_cnt 0, offset 0, half_index 0, half_done 0, overflow 0, running 0, s_axis_tready 0, m_axis_tvalid 0.
  - address = cfg_base with the size bits masked to 0.
  - Reset mid-operation gates the stream the next cycle; the writer drains its own bursts.
- pass = (state==RUN) | (state==DRAIN & beat_cnt!=0).
  - m_axis_tvalid = s_axis_tvalid & pass.
  - s_axis_tready = m_axis_tready & pass.
  - m_axis_tdata = s_axis_tdata. All combinational, zero latency.
- hs = m_axis_tvalid & m_axis_tready.
- Size latch: eff_log2 = clamp(cfg_size_log2, log2(2*BURST_LENGTH*BYTES), BUFFER_LOG2_MAX), latched on start.
- address = (cfg_base & ~mask) | offset, where mask = 2^eff_log2 - 1. Combinational from registers.
- Beat counting:
  - beat_cnt is log2(BURST_LENGTH) bits and increments on hs.
  - On hs with beat_cnt==BURST_LENGTH-1: offset += BURST_LENGTH*BYTES, modulo 2^eff_log2.
  - The new address therefore applies from the first sample of the next group.
- Half completion:
  - A half completes when the offset increment lands on size/2 (half_index 0→1) or wraps to 0 (half_index 1→0).
  - On completion, half_done is set. If half_done is already set and not acked that cycle, overflow is set instead (sticky until next start).
  - cfg_ack clears half_done; a simultaneous completion wins (half_done stays 1, no overflow).
  - half_done means samples were accepted by the writer, not committed to DDR.
- State machine:
  - IDLE: cfg_start → RUN. On that edge: offset, beat_cnt and half_index reset to 0; half_done and overflow cleared; size latched. cfg_stop is ignored.
  - RUN: cfg_stop → DRAIN; cfg_start is ignored; stop and start in the same cycle → stop.
  - DRAIN: streaming continues until beat_cnt==0, then → IDLE the next cycle. Offset is retained for debug; the next start reinitialises it.
- Simultaneous hs and stop: the hs is counted, then DRAIN finishes the group.

Optional Feature:
- Macro S2MM_RAM_WRITER_CTRL_ONESHOT_EN.
- When defined:
  - Adds input cfg_oneshot (1 bit), latched on start.
  - If set, RUN → IDLE automatically on the group completing the second half (offset wrap to 0); exactly one ring fill, no overflow possible.
- When undefined: the port is absent and the ring runs continuously until cfg_stop.

Test Plan:
- Basic walk: BYTES=4, base 0x1000_0000, size_log2 8; start, 64 continuous samples. Address is 0x1000_0000 for samples 0-15, then 0x…40, 0x…80, 0x…C0. half_done rises after sample 31 with half_index→1; wrap to 0x1000_0000 after sample 63.
- Overflow: no ack after the first half; stream 64 samples. Overflow=1 after sample 63, half_done stays 1. Ack clears half_done only; next start clears overflow.
- Stop mid-group: stop after sample 5 → exactly 16 handshakes total, then s_axis_tready=0 and state IDLE. Stop at beat_cnt 0 → no further handshakes.
- Backpressure: m_axis_tready toggling 50% → address changes only on group boundaries; no samples lost or duplicated.
- Clamp/align: size_log2=3 → behaves as 7 (128 B, half every 16 samples). base 0x1000_0123 with size 8 → address 0x1000_0100.
- Reset mid-RUN at beat 9 → next cycle tready=0, all outputs at reset values; a subsequent start begins at the aligned base.
